delay_correlation_accumulator: RTL and testbench



---
 rtl/ofdm_rx_pkg.sv | 11 +
 rtl/corr_window_buffer.sv | 51 +++++
 rtl/delay_correlation_accumulator.sv | 132 +++++++++++++
 tb/tb_delay_correlation_accumulator.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_pkg.sv
// rtl/ofdm_rx_pkg.sv - shared OFDM RX packet-detection constants and helpers
package ofdm_rx_pkg;

  localparam int Q312_W     = 16;
  localparam int STS_PERIOD = 16;

  function automatic logic [31:0] abs_val(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/corr_window_buffer.sv
// rtl/corr_window_buffer.sv - circular window of the last WIN_LEN correlation products
module corr_window_buffer
  import ofdm_rx_pkg::*;
#(
  parameter int WIN_LEN = STS_PERIOD,
  parameter int IN_W    = Q312_W
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic signed [IN_W-1:0] wr_re,
  input  logic signed [IN_W-1:0] wr_im,
  output logic signed [IN_W-1:0] oldest_re,
  output logic signed [IN_W-1:0] oldest_im,
  output logic                   window_full
);

  localparam int PTR_W = $clog2(WIN_LEN);

  logic signed [IN_W-1:0] mem_re [WIN_LEN];
  logic signed [IN_W-1:0] mem_im [WIN_LEN];
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W:0]         fill;

  assign window_full = (fill == (PTR_W+1)'(WIN_LEN));

  // Slots not rewritten since the last flush read as zero, so Clear needs no RAM sweep.
  assign oldest_re = window_full ? mem_re[ptr] : '0;
  assign oldest_im = window_full ? mem_im[ptr] : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr  <= '0;
      fill <= '0;
      for (int i = 0; i < WIN_LEN; i++) begin
        mem_re[i] <= '0;
        mem_im[i] <= '0;
      end
    end else if (clear) begin
      ptr  <= '0;
      fill <= '0;
    end else if (wr_en) begin
      mem_re[ptr] <= wr_re;
      mem_im[ptr] <= wr_im;
      ptr         <= ptr + PTR_W'(1);
      if (!window_full) fill <= fill + (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/delay_correlation_accumulator.sv
// rtl/delay_correlation_accumulator.sv - sliding-window correlation sum, metric and plateau detector
// CORR_MAG_MAXMIN_EN selects the alpha-max-beta-min metric instead of |Re|+|Im|.
module delay_correlation_accumulator
  import ofdm_rx_pkg::*;
#(
  parameter  int WIN_LEN     = STS_PERIOD,
  parameter  int IN_W        = Q312_W,
  parameter  int PLATEAU_LEN = 32,
  localparam int SUM_W       = IN_W + $clog2(WIN_LEN),
  localparam int MET_W       = SUM_W + 1
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Clear,
  input  logic                    InputEnable,
  input  logic signed [IN_W-1:0]  DataInRe,
  input  logic signed [IN_W-1:0]  DataInIm,
  input  logic [MET_W-1:0]        Threshold,
  output logic                    OutputEnable,
  output logic signed [SUM_W-1:0] DataOutRe,
  output logic signed [SUM_W-1:0] DataOutIm,
  output logic [MET_W-1:0]        Metric,
  output logic                    Detected
);

  logic signed [IN_W-1:0]  oldest_re;
  logic signed [IN_W-1:0]  oldest_im;
  logic                    window_full;
  logic                    accept;
  logic signed [SUM_W-1:0] sum_re;
  logic signed [SUM_W-1:0] sum_im;
  logic                    s1_valid;

  assign accept = InputEnable & ~Clear;

  corr_window_buffer #(
    .WIN_LEN (WIN_LEN),
    .IN_W    (IN_W)
  ) u_window (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .clear       (Clear),
    .wr_en       (accept),
    .wr_re       (DataInRe),
    .wr_im       (DataInIm),
    .oldest_re   (oldest_re),
    .oldest_im   (oldest_im),
    .window_full (window_full)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sum_re   <= '0;
      sum_im   <= '0;
      s1_valid <= 1'b0;
    end else if (Clear) begin
      sum_re   <= '0;
      sum_im   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= InputEnable;
      if (InputEnable) begin
        sum_re <= sum_re + SUM_W'(DataInRe) - SUM_W'(oldest_re);
        sum_im <= sum_im + SUM_W'(DataInIm) - SUM_W'(oldest_im);
      end
    end
  end

  logic [31:0]       abs_re_full;
  logic [31:0]       abs_im_full;
  logic [SUM_W-1:0]  mag_re;
  logic [SUM_W-1:0]  mag_im;
  logic [MET_W-1:0]  metric_next;
  logic              unused_abs_msbs;

  assign abs_re_full     = abs_val(32'(sum_re));
  assign abs_im_full     = abs_val(32'(sum_im));
  assign mag_re          = abs_re_full[SUM_W-1:0];
  assign mag_im          = abs_im_full[SUM_W-1:0];
  assign unused_abs_msbs = ^{abs_re_full[31:SUM_W], abs_im_full[31:SUM_W]};

`ifdef CORR_MAG_MAXMIN_EN
  logic [SUM_W-1:0] mag_max;
  logic [SUM_W-1:0] mag_min;
  assign mag_max     = (mag_re >= mag_im) ? mag_re : mag_im;
  assign mag_min     = (mag_re >= mag_im) ? mag_im : mag_re;
  assign metric_next = {1'b0, mag_max} + {2'b00, mag_min[SUM_W-1:1]};
`else
  assign metric_next = {1'b0, mag_re} + {1'b0, mag_im};
`endif

  // window_full still reflects the sample now in stage 2; a concurrent new sample lands next edge.
  logic [7:0] plateau_cnt;
  logic [7:0] plateau_max;
  logic       qualifies;

  assign plateau_max = 8'(PLATEAU_LEN);
  assign qualifies   = window_full && (metric_next >= Threshold);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OutputEnable <= 1'b0;
      DataOutRe    <= '0;
      DataOutIm    <= '0;
      Metric       <= '0;
      Detected     <= 1'b0;
      plateau_cnt  <= '0;
    end else if (Clear || !s1_valid) begin
      OutputEnable <= 1'b0;
      DataOutRe    <= '0;
      DataOutIm    <= '0;
      Metric       <= '0;
      Detected     <= 1'b0;
      if (Clear) plateau_cnt <= '0;
    end else begin
      OutputEnable <= 1'b1;
      DataOutRe    <= sum_re;
      DataOutIm    <= sum_im;
      Metric       <= metric_next;
      if (!qualifies) begin
        plateau_cnt <= '0;
        Detected    <= 1'b0;
      end else if (plateau_cnt != plateau_max) begin
        plateau_cnt <= plateau_cnt + 8'd1;
        Detected    <= (plateau_cnt == plateau_max - 8'd1);
      end else begin
        Detected    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_delay_correlation_accumulator.sv
// tb/tb_delay_correlation_accumulator.sv - randomized self-checking bench for delay_correlation_accumulator
module tb_delay_correlation_accumulator;

  localparam int WIN_LEN = 16;
  localparam int IN_W    = 16;
  localparam int PLAT    = 4;
  localparam int SUM_W   = 20;
  localparam int MET_W   = 21;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             Clear = 1'b0;
  logic             InputEnable = 1'b0;
  logic [IN_W-1:0]  DataInRe = '0;
  logic [IN_W-1:0]  DataInIm = '0;
  logic [MET_W-1:0] Threshold = '0;
  logic             OutputEnable;
  logic [SUM_W-1:0] DataOutRe;
  logic [SUM_W-1:0] DataOutIm;
  logic [MET_W-1:0] Metric;
  logic             Detected;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  delay_correlation_accumulator #(
    .WIN_LEN     (WIN_LEN),
    .IN_W        (IN_W),
    .PLATEAU_LEN (PLAT)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Clear        (Clear),
    .InputEnable  (InputEnable),
    .DataInRe     (DataInRe),
    .DataInIm     (DataInIm),
    .Threshold    (Threshold),
    .OutputEnable (OutputEnable),
    .DataOutRe    (DataOutRe),
    .DataOutIm    (DataOutIm),
    .Metric       (Metric),
    .Detected     (Detected)
  );

  // Reference model: the window is the list of samples accepted since the last flush.
  int win_re[$];
  int win_im[$];
  int run;
  int sample_idx;
  int det_at[$];
  logic p_oe, p_det, e_oe, e_det;
  logic [SUM_W-1:0] p_re, p_im, e_re, e_im;
  logic [MET_W-1:0] p_met, e_met;
  int p_idx, e_idx;

  function automatic int model_metric(input int re, input int im);
    int a;
    int b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
`ifdef CORR_MAG_MAXMIN_EN
    return (a > b) ? a + b / 2 : b + a / 2;
`else
    return a + b;
`endif
  endfunction

  task automatic model_reset();
    win_re.delete();
    win_im.delete();
    run = 0;
    sample_idx = 0;
    p_oe = 0; p_det = 0; p_re = '0; p_im = '0; p_met = '0; p_idx = 0;
    e_oe = 0; e_det = 0; e_re = '0; e_im = '0; e_met = '0; e_idx = 0;
  endtask

  task automatic drive(input logic en, input int re, input int im, input logic clr);
    int sre;
    int sim;
    int met;
    Clear = clr;
    InputEnable = en;
    DataInRe = IN_W'(re);
    DataInIm = IN_W'(im);
    @(posedge Clk);
    #1;
    if (clr) begin
      e_oe = 0; e_det = 0; e_re = '0; e_im = '0; e_met = '0; e_idx = 0;
    end else begin
      e_oe = p_oe; e_det = p_det; e_re = p_re; e_im = p_im; e_met = p_met; e_idx = p_idx;
    end
    p_oe = 0; p_det = 0; p_re = '0; p_im = '0; p_met = '0; p_idx = 0;
    if (clr) begin
      win_re.delete();
      win_im.delete();
      run = 0;
      sample_idx = 0;
    end else if (en) begin
      sample_idx++;
      win_re.push_back(re);
      win_im.push_back(im);
      if (win_re.size() > WIN_LEN) begin
        void'(win_re.pop_front());
        void'(win_im.pop_front());
      end
      sre = 0;
      sim = 0;
      foreach (win_re[i]) begin
        sre += win_re[i];
        sim += win_im[i];
      end
      met = model_metric(sre, sim);
      run = (win_re.size() == WIN_LEN && met >= int'(Threshold)) ? run + 1 : 0;
      p_oe = 1; p_re = SUM_W'(sre); p_im = SUM_W'(sim); p_met = MET_W'(met);
      p_det = (run == PLAT); p_idx = sample_idx;
    end
    if (OutputEnable === 1'b1 && Detected === 1'b1) det_at.push_back(e_idx);
  endtask

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_reset();
    Rst_n = 0; InputEnable = 1; Clear = 0; DataInRe = 16'h1234; DataInIm = 16'h4321;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (OutputEnable !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b want=0", OutputEnable); end
    checks++; if (DataOutRe !== '0) begin failures++; $display("FAIL reset_re got=%h want=0", DataOutRe); end
    checks++; if (DataOutIm !== '0) begin failures++; $display("FAIL reset_im got=%h want=0", DataOutIm); end
    checks++; if (Metric !== '0) begin failures++; $display("FAIL reset_metric got=%h want=0", Metric); end
    checks++; if (Detected !== 1'b0) begin failures++; $display("FAIL reset_det got=%b want=0", Detected); end
    InputEnable = 0;
    Rst_n = 1;
    model_reset();
  endtask

  task automatic test_fill();
    Threshold = '1;
    det_at.delete();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 22; i++) begin
      drive(i < 20, 'h100, 0, 0);
      checks++;
      if (OutputEnable !== e_oe || DataOutRe !== e_re || DataOutIm !== e_im || Metric !== e_met || Detected !== e_det) begin
        failures++;
        $display("FAIL fill step %0d got oe=%b re=%h im=%h met=%h det=%b want oe=%b re=%h im=%h met=%h det=%b", i, OutputEnable, DataOutRe, DataOutIm, Metric, Detected, e_oe, e_re, e_im, e_met, e_det);
      end
      if (e_oe && e_idx == 16) begin
        checks++;
        if (DataOutRe !== 20'h01000 || Metric !== 21'h01000) begin
          failures++; $display("FAIL fill_full got re=%h met=%h want re=01000 met=01000", DataOutRe, Metric);
        end
      end
    end
    checks++; if (det_at.size() != 0) begin failures++; $display("FAIL fill_nodet got=%0d want=0", det_at.size()); end
  endtask

  task automatic test_wrap();
    Threshold = '1;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 34; i++) begin
      drive(i < 32, (i < 16) ? 'h100 : -'h100, (i < 16) ? 'h100 : 0, 0);
      checks++;
      if (OutputEnable !== e_oe || DataOutRe !== e_re || DataOutIm !== e_im || Metric !== e_met || Detected !== e_det) begin
        failures++;
        $display("FAIL wrap step %0d got oe=%b re=%h im=%h met=%h det=%b want oe=%b re=%h im=%h met=%h det=%b", i, OutputEnable, DataOutRe, DataOutIm, Metric, Detected, e_oe, e_re, e_im, e_met, e_det);
      end
      if (e_oe && e_idx == 32) begin
        checks++;
        if (DataOutRe !== 20'hFF000 || DataOutIm !== 20'h00000) begin
          failures++; $display("FAIL wrap_end got re=%h im=%h want re=ff000 im=00000", DataOutRe, DataOutIm);
        end
      end
    end
  endtask

  task automatic test_detect();
    Threshold = 21'h00800;
    det_at.delete();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 102; i++) begin
      drive(i < 100, 'h100, 0, 0);
      checks++;
      if (OutputEnable !== e_oe || DataOutRe !== e_re || DataOutIm !== e_im || Metric !== e_met || Detected !== e_det) begin
        failures++;
        $display("FAIL detect step %0d got oe=%b re=%h met=%h det=%b want oe=%b re=%h met=%h det=%b", i, OutputEnable, DataOutRe, Metric, Detected, e_oe, e_re, e_met, e_det);
      end
    end
    checks++;
    if (det_at.size() != 1 || det_at[0] != 19) begin
      failures++; $display("FAIL detect_once got count=%0d first=%0d want count=1 first=19", det_at.size(), (det_at.size() > 0) ? det_at[0] : -1);
    end
  endtask

  task automatic test_plateau_break();
    Threshold = 21'h00F80;
    det_at.delete();
    drive(0, 0, 0, 1);
    for (int i = 1; i <= 57; i++) begin
      drive(i <= 55, (i == 25) ? 0 : 'h100, 0, 0);
      checks++;
      if (OutputEnable !== e_oe || DataOutRe !== e_re || DataOutIm !== e_im || Metric !== e_met || Detected !== e_det) begin
        failures++;
        $display("FAIL plateau step %0d got oe=%b re=%h met=%h det=%b want oe=%b re=%h met=%h det=%b", i, OutputEnable, DataOutRe, Metric, Detected, e_oe, e_re, e_met, e_det);
      end
    end
    checks++;
    if (det_at.size() != 2 || det_at[0] != 19 || det_at[1] != 44) begin
      failures++; $display("FAIL plateau_redetect got count=%0d want count=2 at 19,44", det_at.size());
    end
  endtask

  task automatic test_gaps_clear();
    int a;
    int b;
    Threshold = '1;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 26; i++) begin
      drive((i < 24) && (i % 2 == 0), rnd_s16(), rnd_s16(), 0);
      checks++;
      if (OutputEnable !== e_oe || DataOutRe !== e_re || DataOutIm !== e_im || Metric !== e_met || Detected !== e_det) begin
        failures++;
        $display("FAIL gaps step %0d got oe=%b re=%h im=%h met=%h want oe=%b re=%h im=%h met=%h", i, OutputEnable, DataOutRe, DataOutIm, Metric, e_oe, e_re, e_im, e_met);
      end
    end
    drive(1, 'h0500, 'h0600, 0);
    drive(1, rnd_s16(), rnd_s16(), 1);
    checks++; if (OutputEnable !== 1'b0) begin failures++; $display("FAIL clear_kill got oe=%b want 0", OutputEnable); end
    a = rnd_s16();
    b = rnd_s16();
    drive(1, a, b, 0);
    checks++; if (OutputEnable !== 1'b0) begin failures++; $display("FAIL clear_drop got oe=%b want 0", OutputEnable); end
    drive(0, 0, 0, 0);
    checks++;
    if (OutputEnable !== 1'b1 || DataOutRe !== SUM_W'(a) || DataOutIm !== SUM_W'(b)) begin
      failures++; $display("FAIL clear_first got oe=%b re=%h im=%h want oe=1 re=%h im=%h", OutputEnable, DataOutRe, DataOutIm, SUM_W'(a), SUM_W'(b));
    end
  endtask

  task automatic test_threshold_zero();
    Threshold = '0;
    det_at.delete();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 26; i++) begin
      drive(i < 24, rnd_s16(), rnd_s16(), 0);
      checks++;
      if (OutputEnable !== e_oe || DataOutRe !== e_re || DataOutIm !== e_im || Metric !== e_met || Detected !== e_det) begin
        failures++;
        $display("FAIL thr0 step %0d got oe=%b re=%h met=%h det=%b want oe=%b re=%h met=%h det=%b", i, OutputEnable, DataOutRe, Metric, Detected, e_oe, e_re, e_met, e_det);
      end
    end
    checks++;
    if (det_at.size() != 1 || det_at[0] != WIN_LEN + PLAT - 1) begin
      failures++; $display("FAIL thr0_detect got count=%0d want count=1 at %0d", det_at.size(), WIN_LEN + PLAT - 1);
    end
  endtask

  task automatic test_random();
    for (int pass = 0; pass < 2; pass++) begin
      Threshold = MET_W'((pass == 0) ? $urandom_range(0, 'h40000) : $urandom_range(0, 'h2000));
      drive(0, 0, 0, 1);
      for (int i = 0; i < 202; i++) begin
        if (i < 200)
          drive($urandom_range(0, 3) != 0, (pass == 0) ? rnd_s16() : int'($urandom_range(0, 'h300)),
                rnd_s16() / ((pass == 0) ? 1 : 64), $urandom_range(0, 60) == 0);
        else
          drive(0, 0, 0, 0);
        checks++;
        if (OutputEnable !== e_oe || DataOutRe !== e_re || DataOutIm !== e_im || Metric !== e_met || Detected !== e_det) begin
          failures++;
          $display("FAIL random p%0d step %0d got oe=%b re=%h im=%h met=%h det=%b want oe=%b re=%h im=%h met=%h det=%b", pass, i, OutputEnable, DataOutRe, DataOutIm, Metric, Detected, e_oe, e_re, e_im, e_met, e_det);
        end
      end
    end
  endtask

  task automatic test_metric_mode();
    logic [MET_W-1:0] want;
`ifdef CORR_MAG_MAXMIN_EN
    want = 21'h03800;
`else
    want = 21'h04000;
`endif
    Threshold = '1;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 18; i++) begin
      drive(i < 16, 'h300, -'h100, 0);
      if (e_oe && e_idx == 16) begin
        checks++;
        if (Metric !== want) begin failures++; $display("FAIL metric_mode got=%h want=%h", Metric, want); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int a;
    int b;
    Threshold = '1;
    for (int i = 0; i < 10; i++) drive(1, rnd_s16(), rnd_s16(), 0);
    Rst_n = 0;
    #2;
    checks++;
    if (OutputEnable !== 1'b0 || DataOutRe !== '0 || Metric !== '0) begin
      failures++; $display("FAIL midreset got oe=%b re=%h met=%h want all 0", OutputEnable, DataOutRe, Metric);
    end
    @(posedge Clk);
    #1;
    Rst_n = 1;
    model_reset();
    a = rnd_s16();
    b = rnd_s16();
    drive(1, a, b, 0);
    drive(0, 0, 0, 0);
    checks++;
    if (OutputEnable !== 1'b1 || DataOutRe !== SUM_W'(a) || DataOutIm !== SUM_W'(b)) begin
      failures++; $display("FAIL midreset_first got oe=%b re=%h im=%h want oe=1 re=%h im=%h", OutputEnable, DataOutRe, DataOutIm, SUM_W'(a), SUM_W'(b));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_wrap();
    test_detect();
    test_plateau_break();
    test_gaps_clear();
    test_threshold_zero();
    test_random();
    test_metric_mode();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
